// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: loads up to NUM_SLOTS sprites per line during hblank
// and time-shares one synchronous sprite ROM across them during active video.
//
// state  | meaning
// IDLE   | waiting for DrawX == 640 to start evaluating the next line
// SCAN   | testing one object per cycle against the target line, filling shadow slots
// COMMIT | shadow slots and overflow become the active set; shadow cleared
module sprite_line_scheduler #(
  parameter int NUM_OBJ    = 8,
  parameter int NUM_SLOTS  = 4,
  parameter int SPR_SIZE   = 26,
  parameter int IMG_W      = 3,
  parameter int ROM_AW     = 13,
  parameter int PIX_W      = 4,
  parameter int TRANSP_IDX = 0
) (
  input  logic                     vga_clk,
  input  logic                     reset_n,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic                     blank,
  input  logic [NUM_OBJ*10-1:0]    obj_x,
  input  logic [NUM_OBJ*10-1:0]    obj_y,
  input  logic [NUM_OBJ*IMG_W-1:0] obj_img,
  input  logic [NUM_OBJ-1:0]       obj_en,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [PIX_W-1:0]         rom_q,
  output logic                     spr_on,
  output logic [PIX_W-1:0]         spr_pix,
  output logic                     line_overflow,
  output logic                     eval_busy
);

  localparam int ROW_W  = $clog2(SPR_SIZE);
  localparam int IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam logic [9:0] HBLANK_X = 10'd640;
  localparam logic [9:0] LAST_Y   = 10'd524;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  typedef struct packed {
    logic             vld;
    logic [9:0]       x;
    logic [IMG_W-1:0] img;
    logic [ROW_W-1:0] row;
  } slot_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [9:0]       target_q;
  logic [CNT_W-1:0] sh_cnt_q;
  logic             sh_ovf_q;
  logic             ovf_q;
  logic             busy_q;
  slot_t            sh_q  [NUM_SLOTS];
  slot_t            act_q [NUM_SLOTS];

  logic [9:0]       cur_x;
  logic [9:0]       cur_y;
  logic [IMG_W-1:0] cur_img;
  logic             cur_en;
  logic             scan_hit;
  logic [ROW_W-1:0] scan_row;

  always_comb begin
    cur_x    = obj_x[int'(idx_q)*10 +: 10];
    cur_y    = obj_y[int'(idx_q)*10 +: 10];
    cur_img  = obj_img[int'(idx_q)*IMG_W +: IMG_W];
    cur_en   = obj_en[idx_q];
    // 11-bit compare so sprites near the bottom of the 10-bit range never wrap onto line 0
    scan_hit = cur_en && ({1'b0, target_q} >= {1'b0, cur_y}) &&
               ({1'b0, target_q} < ({1'b0, cur_y} + 11'(SPR_SIZE)));
    scan_row = ROW_W'(target_q - cur_y);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      target_q <= '0;
      sh_cnt_q <= '0;
      sh_ovf_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        sh_q[s]  <= '0;
        act_q[s] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (DrawX == HBLANK_X) begin
            state_q  <= SCAN;
            busy_q   <= 1'b1;
            idx_q    <= '0;
            target_q <= (DrawY == LAST_Y) ? 10'd0 : DrawY + 10'd1;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            if (sh_cnt_q < CNT_W'(NUM_SLOTS)) begin
              sh_q[sh_cnt_q[SLOT_W-1:0]] <= slot_t'{vld: 1'b1, x: cur_x, img: cur_img, row: scan_row};
              sh_cnt_q <= sh_cnt_q + CNT_W'(1);
            end else begin
              sh_ovf_q <= 1'b1;
            end
          end
          if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        COMMIT: begin
          for (int s = 0; s < NUM_SLOTS; s++) begin
            act_q[s] <= sh_q[s];
            sh_q[s]  <= '0;
          end
          ovf_q    <= sh_ovf_q;
          sh_ovf_q <= 1'b0;
          sh_cnt_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic              pix_hit;
  logic [SLOT_W-1:0] pix_sel;
  logic [ROM_AW-1:0] rom_addr_d;

  // Lowest slot wins; a transparent winner still owns the single ROM port.
  always_comb begin
    pix_hit = 1'b0;
    pix_sel = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (act_q[s].vld && ({1'b0, DrawX} >= {1'b0, act_q[s].x}) &&
          ({1'b0, DrawX} < ({1'b0, act_q[s].x} + 11'(SPR_SIZE)))) begin
        pix_hit = 1'b1;
        pix_sel = SLOT_W'(s);
      end
    end
    rom_addr_d = ROM_AW'(act_q[pix_sel].img) * ROM_AW'(SPR_SIZE * SPR_SIZE) +
                 ROM_AW'(act_q[pix_sel].row) * ROM_AW'(SPR_SIZE) +
                 ROM_AW'(DrawX - act_q[pix_sel].x);
  end

  logic [ROM_AW-1:0] rom_addr_q;
  logic              hit1_q;
  logic              hit2_q;
  logic              spr_on_q;
  logic [PIX_W-1:0]  spr_pix_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      spr_on_q   <= 1'b0;
      spr_pix_q  <= '0;
    end else begin
      if (pix_hit) begin
        rom_addr_q <= rom_addr_d;
      end
      hit1_q    <= pix_hit && blank;
      hit2_q    <= hit1_q;
      spr_on_q  <= hit2_q && (rom_q != PIX_W'(TRANSP_IDX));
      spr_pix_q <= (hit2_q && (rom_q != PIX_W'(TRANSP_IDX))) ? rom_q : '0;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign spr_on        = spr_on_q;
  assign spr_pix       = spr_pix_q;
  assign line_overflow = ovf_q;
  assign eval_busy     = busy_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: directed vector table, hand-written corner sequences,
// and randomized lines checked against a per-line object-list reference model.
module tb_sprite_line_scheduler;
  localparam int NO = 8;
  localparam int NS = 4;
  localparam int SZ = 26;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [79:0] obj_x, obj_y;
  logic [23:0] obj_img;
  logic [7:0]  obj_en;
  logic [12:0] rom_addr;
  logic [3:0]  rom_q = 4'd0;
  logic        spr_on;
  logic [3:0]  spr_pix;
  logic        line_overflow;
  logic        eval_busy;

  logic [3:0]  rom_mem [0:8191];

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

  sprite_line_scheduler dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .obj_x(obj_x), .obj_y(obj_y), .obj_img(obj_img), .obj_en(obj_en),
    .rom_addr(rom_addr), .rom_q(rom_q), .spr_on(spr_on), .spr_pix(spr_pix),
    .line_overflow(line_overflow), .eval_busy(eval_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  // object table as seen by the bench
  int ox [NO];
  int oy [NO];
  int oimg [NO];
  bit oen [NO];

  // reference model: active sprite list for the current line
  int m_x [NS];
  int m_img [NS];
  int m_row [NS];
  int m_cnt;
  bit m_ovf;
  int m_addr;
  bit e_on [3];
  int e_pix [3];
  // pending list built at evaluation time
  int n_x [NS];
  int n_img [NS];
  int n_row [NS];
  int n_cnt;
  bit n_ovf;

  typedef struct {
    int line;
    int x;
    bit bl;
    int eaddr;
    bit eon;
    int epix;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put_objs();
    for (int i = 0; i < NO; i++) begin
      obj_x[i*10 +: 10]  = 10'(ox[i]);
      obj_y[i*10 +: 10]  = 10'(oy[i]);
      obj_img[i*3 +: 3]  = 3'(oimg[i]);
      obj_en[i]          = oen[i];
    end
  endtask

  task automatic clear_objs();
    for (int i = 0; i < NO; i++) begin
      ox[i] = 0; oy[i] = 0; oimg[i] = 0; oen[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ovf = 1'b0; m_addr = 0;
    for (int i = 0; i < 3; i++) begin
      e_on[i] = 1'b0; e_pix[i] = 0;
    end
  endtask

  // Priority list for line t: enabled objects covering t, in index order, first NS kept.
  task automatic build(input int t);
    n_cnt = 0; n_ovf = 1'b0;
    for (int i = 0; i < NO; i++) begin
      if (oen[i] && t >= oy[i] && t < oy[i] + SZ) begin
        if (n_cnt < NS) begin
          n_x[n_cnt] = ox[i]; n_img[n_cnt] = oimg[i]; n_row[n_cnt] = t - oy[i];
          n_cnt++;
        end else begin
          n_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input int x, input bit bl);
    bit hit;
    bit on;
    int pix;
    DrawX = 10'(x);
    blank = bl;
    hit = 1'b0;
    for (int s = 0; s < m_cnt; s++) begin
      if (!hit && x >= m_x[s] && x < m_x[s] + SZ) begin
        hit = 1'b1;
        m_addr = (m_img[s] * SZ * SZ + m_row[s] * SZ + (x - m_x[s])) % 8192;
      end
    end
    on  = hit && bl && (rom_mem[m_addr] != 4'd0);
    pix = on ? int'(rom_mem[m_addr]) : 0;
    e_on[2] = e_on[1]; e_pix[2] = e_pix[1];
    e_on[1] = e_on[0]; e_pix[1] = e_pix[0];
    e_on[0] = on;      e_pix[0] = pix;
    @(posedge vga_clk);
    #1;
    chk("rom_addr", rom_addr, m_addr);
    chk("spr_on", spr_on, e_on[2]);
    chk("spr_pix", spr_pix, e_pix[2]);
    chk("line_overflow", line_overflow, m_ovf);
  endtask

  // Hblank evaluation for target line t; the object table must hold x <= 600 so no
  // active sprite covers DrawX >= 640.
  task automatic do_eval(input int t);
    DrawY = (t == 0) ? 10'd524 : 10'(t - 1);
    build(t);
    for (int j = 0; j < 12; j++) begin
      step(640 + j, 1'b0);
      chk("eval_busy", eval_busy, (j <= 8) ? 1 : 0);
      if (j == 8) begin
        m_cnt = n_cnt; m_ovf = n_ovf;
        for (int s = 0; s < NS; s++) begin
          m_x[s] = n_x[s]; m_img[s] = n_img[s]; m_row[s] = n_row[s];
        end
      end
    end
    DrawY = 10'(t);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur_line;
    int t;
    int r;
    int xx;
    int s;

    vecs[0] = '{50, 100, 1'b1, 1352, 1'b1, 5};
    vecs[1] = '{50, 125, 1'b1, 1377, 1'b1, 9};
    vecs[2] = '{50, 126, 1'b1, 1377, 1'b0, 0};
    vecs[3] = '{50,  99, 1'b1, 1377, 1'b0, 0};
    vecs[4] = '{50, 110, 1'b0, 1362, 1'b0, 0};
    vecs[5] = '{50, 112, 1'b1, 1364, 1'b0, 0};
    vecs[6] = '{90, 200, 1'b1, 2964, 1'b1, 7};
    vecs[7] = '{90, 225, 1'b1, 2989, 1'b1, 11};
    vecs[8] = '{90, 226, 1'b1, 2989, 1'b0, 0};
    vecs[9] = '{90, 112, 1'b1, 2989, 1'b0, 0};

    for (int i = 0; i < 8192; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    rom_mem[1352] = 4'd5;  rom_mem[1377] = 4'd9;  rom_mem[1362] = 4'd4;
    rom_mem[1364] = 4'd0;  rom_mem[688]  = 4'd3;  rom_mem[2964] = 4'd7;
    rom_mem[2989] = 4'd11; rom_mem[4316] = 4'd6;

    reset_n = 1'b0; DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
    clear_objs(); put_objs();
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_spr_on", spr_on, 0);
    chk("rst_spr_pix", spr_pix, 0);
    chk("rst_overflow", line_overflow, 0);
    chk("rst_busy", eval_busy, 0);
    reset_n = 1'b1;

    // directed table: obj0 over obj1 at (100,50), obj2 over obj3 at (200,80)
    ox[0] = 100; oy[0] = 50; oimg[0] = 2; oen[0] = 1'b1;
    ox[1] = 100; oy[1] = 50; oimg[1] = 1; oen[1] = 1'b1;
    ox[2] = 200; oy[2] = 80; oimg[2] = 4; oen[2] = 1'b1;
    ox[3] = 200; oy[3] = 80; oimg[3] = 6; oen[3] = 1'b1;
    put_objs();
    cur_line = -1;
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].line != cur_line) begin
        do_eval(vecs[v].line);
        cur_line = vecs[v].line;
      end
      step(vecs[v].x, vecs[v].bl);
      chk("vec_addr", rom_addr, vecs[v].eaddr);
      step(0, 1'b0);
      step(0, 1'b0);
      chk("vec_on", spr_on, vecs[v].eon);
      chk("vec_pix", spr_pix, vecs[v].epix);
    end

    // five objects on line 60: obj4 is dropped
    clear_objs();
    for (int i = 0; i < 5; i++) begin
      ox[i] = 20 + 60 * i; oy[i] = 40 + 4 * i; oimg[i] = i; oen[i] = 1'b1;
    end
    put_objs();
    do_eval(60);
    chk("ovf_set", line_overflow, 1);
    step(25, 1'b1);
    chk("ovf_obj0_addr", rom_addr, 525);
    for (int x = 260; x < 286; x++) step(x, 1'b1);
    chk("obj4_not_drawn", rom_addr, 525);

    // reset in the middle of SCAN for line 61
    DrawY = 10'd60;
    step(640, 1'b0);
    step(641, 1'b0);
    step(642, 1'b0);
    chk("busy_in_scan", eval_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midscan_rom_addr", rom_addr, 0);
    chk("midscan_spr_on", spr_on, 0);
    chk("midscan_spr_pix", spr_pix, 0);
    chk("midscan_overflow", line_overflow, 0);
    chk("midscan_busy", eval_busy, 0);
    model_reset();
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    DrawY = 10'd61;
    for (int x = 15; x < 50; x++) step(x, 1'b1);
    chk("post_rst_addr", rom_addr, 0);
    chk("post_rst_on", spr_on, 0);

    oy[4] = 300;
    put_objs();
    do_eval(60);
    chk("ovf_clear", line_overflow, 0);
    step(25, 1'b1);
    chk("post_rst_draw", rom_addr, 525);
    for (int x = 255; x < 290; x++) step(x, 1'b1);

    // line wrap: evaluation at DrawY=524 targets line 0
    clear_objs();
    ox[0] = 300; oy[0] = 0;   oimg[0] = 3; oen[0] = 1'b1;
    ox[1] = 400; oy[1] = 510; oimg[1] = 5; oen[1] = 1'b1;
    put_objs();
    do_eval(0);
    step(300, 1'b1);
    chk("wrap_obj0", rom_addr, 2028);
    step(410, 1'b1);
    chk("wrap_obj1_absent", rom_addr, 2028);
    step(0, 1'b0);
    step(0, 1'b0);

    // randomized lines
    for (int ln = 0; ln < 25; ln++) begin
      t = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 479));
      for (int i = 0; i < NO; i++) begin
        r = int'($urandom_range(0, 31));
        ox[i] = int'($urandom_range(0, 600));
        oy[i] = t - 28 + r;
        if (oy[i] < 0) oy[i] = oy[i] + 525;
        oimg[i] = int'($urandom_range(0, 7));
        oen[i] = ($urandom_range(0, 4) != 0);
      end
      put_objs();
      do_eval(t);
      // table is not sampled outside SCAN
      for (int i = 0; i < NO; i++) begin
        ox[i] = int'($urandom_range(0, 600)); oy[i] = int'($urandom_range(0, 1023));
        oimg[i] = int'($urandom_range(0, 7)); oen[i] = $urandom_range(0, 1);
      end
      put_objs();
      for (int p = 0; p < 150; p++) begin
        if (m_cnt > 0 && $urandom_range(0, 1) == 1) begin
          s = int'($urandom_range(0, m_cnt - 1));
          xx = m_x[s] - 2 + int'($urandom_range(0, 30));
          if (xx < 0) xx = 0;
          if (xx > 639) xx = 639;
        end else begin
          xx = int'($urandom_range(0, 639));
        end
        step(xx, ($urandom_range(0, 7) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
